// File: rtl/ccu_pkg.sv
// Shared CCU packet-path definitions.
// The start byte is common to packer and unpacker so both ends always agree.
package ccu_pkg;

    localparam logic [7:0]  CCU_START_BYTE = 8'h5A;
    localparam int unsigned CCU_HDR_BYTES  = 6;
    localparam int unsigned CCU_ID_W       = 16;
    localparam int unsigned CCU_LEN_W      = 13;
    localparam int unsigned CCU_IDLE_W     = 16;

    // Receive parser states, in wire order of the header bytes.
    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_ID_LB  = 3'd1,
        ST_ID_HB  = 3'd2,
        ST_LEN_LB = 3'd3,
        ST_LEN_HB = 3'd4,
        ST_TYPE   = 3'd5,
        ST_DATA   = 3'd6
    } ccu_state_e;

    // Framing error codes reported on pack_err_code.
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN_MAX = 2'd1,
        ERR_LEN_HI  = 2'd2,
        ERR_TIMEOUT = 2'd3
    } ccu_err_e;

    // Header fields collected before they are published.
    typedef struct packed {
        logic [CCU_ID_W-1:0]  id;
        logic [CCU_LEN_W-1:0] length;
    } ccu_hdr_t;

endpackage

// File: rtl/ccu_unpack_if.sv
// Byte-stream bus around the unpacker.
//   s_axis_tdata/tvalid/tready : SPI RX AXI4-Stream bytes into the unpacker
//   m_data/m_valid/m_ready/m_last : payload bytes out to the CCU FSMs
// Modport slave is the unpacker side; modport master is the surrounding logic
// that feeds RX bytes and consumes payload.
interface ccu_unpack_if;

    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        input  m_ready,
        output s_axis_tready,
        output m_data,
        output m_valid,
        output m_last
    );

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        output m_ready,
        input  s_axis_tready,
        input  m_data,
        input  m_valid,
        input  m_last
    );

endinterface

// File: rtl/ccu_unpack.sv
// CCU receive unpacker: hunts for the start byte, parses the 6-byte header
// (start, ID LB/HB, LEN LB/HB, TYPE) and forwards LEN payload bytes through a
// one-entry output register.
// Ports:
//   axi_aclk, axi_aresetn : clock, asynchronous active-low reset
//   bus (slave)           : RX byte stream in, payload byte stream out
//   pack_id/length/type   : header of the current packet, valid with pack_hdr_valid
//   pack_done             : pulse after the last payload byte is taken
//   pack_err/_code        : framing error pulse, code held until next error
// Optional: define CCU_UNPACK_TIMEOUT_EN to abort a packet after
// TIMEOUT_CYCLES idle cycles (error code 3).
module ccu_unpack
    import ccu_pkg::*;
#(
    parameter logic [12:0] MAX_LEN        = 13'd4096,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                 axi_aclk,
    input  logic                 axi_aresetn,
    ccu_unpack_if.slave          bus,
    output logic [CCU_ID_W-1:0]  pack_id,
    output logic [CCU_LEN_W-1:0] pack_length,
    output logic [7:0]           pack_type,
    output logic                 pack_hdr_valid,
    output logic                 pack_done,
    output logic                 pack_err,
    output logic [1:0]           pack_err_code
);

    ccu_state_e           state;
    ccu_hdr_t             hdr_sh;
    logic [7:0]           len_lb;
    logic [CCU_LEN_W-1:0] data_ct;
    logic [7:0]           m_data_q;
    logic                 m_valid_q;
    logic                 m_last_q;
    logic                 zl_pend;

    logic                 s_ready_c;
    logic                 s_hs_c;
    logic                 m_hs_c;
    logic                 last_load_c;
    logic                 timeout_c;
    logic [CCU_LEN_W-1:0] len_wire_c;

    // Accept rules: TYPE waits until the previous header is released,
    // DATA only loads when the output register is free or draining.
    always_comb begin
        s_ready_c = 1'b1;
        case (state)
            ST_TYPE: s_ready_c = !pack_hdr_valid;
            ST_DATA: s_ready_c = !m_valid_q || bus.m_ready;
            default: s_ready_c = 1'b1;
        endcase
    end

    assign s_hs_c      = bus.s_axis_tvalid && s_ready_c;
    assign m_hs_c      = m_valid_q && bus.m_ready;
    assign last_load_c = (state == ST_DATA) && s_hs_c
                         && (data_ct == pack_length - 13'd1);
    assign len_wire_c  = {bus.s_axis_tdata[4:0], len_lb};

    assign bus.s_axis_tready = s_ready_c;
    assign bus.m_data        = m_data_q;
    assign bus.m_valid       = m_valid_q;
    assign bus.m_last        = m_last_q;

`ifdef CCU_UNPACK_TIMEOUT_EN
    logic [CCU_IDLE_W-1:0] idle_ct;

    // Counts only genuine idle cycles; a stalled but valid byte is not idle.
    assign timeout_c = (state != ST_HUNT) && !bus.s_axis_tvalid
                       && (idle_ct + 16'd1 == TIMEOUT_CYCLES);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            idle_ct <= '0;
        end else if (state == ST_HUNT || s_hs_c || timeout_c) begin
            idle_ct <= '0;
        end else if (!bus.s_axis_tvalid) begin
            idle_ct <= idle_ct + 16'd1;
        end
    end
`else
    // Timeout limit has no effect in this build.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_c      = 1'b0;
`endif

    // Parser state, header registers, output register and status pulses.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state          <= ST_HUNT;
            hdr_sh         <= '0;
            len_lb         <= '0;
            data_ct        <= '0;
            m_data_q       <= '0;
            m_valid_q      <= 1'b0;
            m_last_q       <= 1'b0;
            zl_pend        <= 1'b0;
            pack_id        <= '0;
            pack_length    <= '0;
            pack_type      <= '0;
            pack_hdr_valid <= 1'b0;
            pack_done      <= 1'b0;
            pack_err       <= 1'b0;
            pack_err_code  <= ERR_NONE;
        end else begin
            pack_done <= 1'b0;
            pack_err  <= 1'b0;

            // Output register drains independently of the parser state.
            if (m_hs_c) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
                if (m_last_q) begin
                    pack_done      <= 1'b1;
                    pack_hdr_valid <= 1'b0;
                end
            end

            // Zero-length packet completes the cycle after its TYPE byte.
            if (zl_pend) begin
                zl_pend        <= 1'b0;
                pack_done      <= 1'b1;
                pack_hdr_valid <= 1'b0;
            end

            if (timeout_c) begin
                pack_err       <= 1'b1;
                pack_err_code  <= ERR_TIMEOUT;
                m_valid_q      <= 1'b0;
                m_last_q       <= 1'b0;
                pack_hdr_valid <= 1'b0;
                zl_pend        <= 1'b0;
                state          <= ST_HUNT;
            end else if (s_hs_c) begin
                case (state)
                    ST_HUNT: begin
                        if (bus.s_axis_tdata == CCU_START_BYTE) begin
                            state <= ST_ID_LB;
                        end
                    end
                    ST_ID_LB: begin
                        hdr_sh.id[7:0] <= bus.s_axis_tdata;
                        state          <= ST_ID_HB;
                    end
                    ST_ID_HB: begin
                        hdr_sh.id[15:8] <= bus.s_axis_tdata;
                        state           <= ST_LEN_LB;
                    end
                    ST_LEN_LB: begin
                        len_lb <= bus.s_axis_tdata;
                        state  <= ST_LEN_HB;
                    end
                    ST_LEN_HB: begin
                        if (bus.s_axis_tdata[7:5] != 3'd0) begin
                            pack_err      <= 1'b1;
                            pack_err_code <= ERR_LEN_HI;
                            state         <= ST_HUNT;
                        end else if (len_wire_c > MAX_LEN) begin
                            pack_err      <= 1'b1;
                            pack_err_code <= ERR_LEN_MAX;
                            state         <= ST_HUNT;
                        end else begin
                            hdr_sh.length <= len_wire_c;
                            state         <= ST_TYPE;
                        end
                    end
                    ST_TYPE: begin
                        // Publish the header only once it is complete and legal.
                        pack_id        <= hdr_sh.id;
                        pack_length    <= hdr_sh.length;
                        pack_type      <= bus.s_axis_tdata;
                        pack_hdr_valid <= 1'b1;
                        data_ct        <= '0;
                        if (hdr_sh.length == 13'd0) begin
                            zl_pend <= 1'b1;
                            state   <= ST_HUNT;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        m_data_q  <= bus.s_axis_tdata;
                        m_valid_q <= 1'b1;
                        m_last_q  <= last_load_c;
                        data_ct   <= data_ct + 13'd1;
                        if (last_load_c) begin
                            state <= ST_HUNT;
                        end
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ccu_unpack.sv
// Scoreboard bench for ccu_unpack: frames are queued as expected payload,
// header and error records when driven, and retired as the DUT emits them.
module tb_ccu_unpack;
    import ccu_pkg::*;

    localparam int unsigned TO_CYC = 100;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn = 1'b0;
    logic [15:0] pack_id;
    logic [12:0] pack_length;
    logic [7:0]  pack_type;
    logic        pack_hdr_valid;
    logic        pack_done;
    logic        pack_err;
    logic [1:0]  pack_err_code;

    ccu_unpack_if bus();

    ccu_unpack #(
        .MAX_LEN        (13'd4096),
        .TIMEOUT_CYCLES (16'(TO_CYC))
    ) dut (
        .axi_aclk       (axi_aclk),
        .axi_aresetn    (axi_aresetn),
        .bus            (bus.slave),
        .pack_id        (pack_id),
        .pack_length    (pack_length),
        .pack_type      (pack_type),
        .pack_hdr_valid (pack_hdr_valid),
        .pack_done      (pack_done),
        .pack_err       (pack_err),
        .pack_err_code  (pack_err_code)
    );

    always #5 axi_aclk = ~axi_aclk;

    int          total = 0;
    int          bad = 0;
    beat_t       sb_q[$];
    logic [36:0] hdr_q[$];
    logic [1:0]  err_q[$];
    int          hs_cyc[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    logic        chk_bp = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // m_ready pattern: 0 = always ready, 1 = toggle, 2 = held low.
    initial begin
        forever begin
            @(posedge axi_aclk);
            #1;
            case (rdy_mode)
                1:       bus.m_ready = ~bus.m_ready;
                2:       bus.m_ready = 1'b0;
                default: bus.m_ready = 1'b1;
            endcase
        end
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge axi_aclk) begin
        beat_t       e;
        logic [36:0] h;
        logic [1:0]  ec;
        if (axi_aresetn) begin
            cyc++;
            if (bus.m_valid && bus.m_ready) begin
                hs_cyc.push_back(cyc);
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'(sb_q.size()), 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("m_data", 64'(bus.m_data), 64'(e.d));
                    chk("m_last", 64'(bus.m_last), 64'(e.l));
                end
            end
            if (pack_done) begin
                done_cnt++;
                if (hdr_q.size() == 0) begin
                    chk("hdr_underflow", 64'(hdr_q.size()), 64'd1);
                end else begin
                    h = hdr_q.pop_front();
                    chk("header", 64'({pack_id, pack_length, pack_type}), 64'(h));
                end
            end
            if (pack_err) begin
                err_cnt++;
                if (err_q.size() == 0) begin
                    chk("err_underflow", 64'(err_q.size()), 64'd1);
                end else begin
                    ec = err_q.pop_front();
                    chk("err_code", 64'(pack_err_code), 64'(ec));
                end
            end
        end
    end

    // Present one byte and hold it until accepted; returns at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.s_axis_tdata  = b;
        bus.s_axis_tvalid = 1'b1;
        @(negedge axi_aclk);
        while (!bus.s_axis_tready && n < 1000) begin
            if (chk_bp && bus.m_valid && !bus.m_ready)
                chk("bp_tready", 64'(bus.s_axis_tready), 64'd0);
            @(negedge axi_aclk);
            n++;
        end
        if (n >= 1000) chk("tready_timeout", 64'(n), 64'd0);
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] id, input logic [12:0] len,
                              input logic [7:0] typ, input logic [7:0] base,
                              input logic [7:0] step);
        beat_t e;
        hdr_q.push_back({id, len, typ});
        for (int i = 0; i < int'(len); i++) begin
            e.d = base + 8'(i) * step;
            e.l = (i == int'(len) - 1);
            sb_q.push_back(e);
        end
        send_byte(CCU_START_BYTE);
        send_byte(id[7:0]);
        send_byte(id[15:8]);
        send_byte({3'd0, len[4:0]} | 8'(len & 13'h00e0));
        send_byte(8'(len >> 8));
        send_byte(typ);
        chk_bp = 1'b1;
        for (int i = 0; i < int'(len); i++) send_byte(base + 8'(i) * step);
        chk_bp = 1'b0;
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        bus.s_axis_tvalid = 1'b0;
        while ((sb_q.size() + hdr_q.size() + err_q.size()) != 0 && n < 10000) begin
            @(negedge axi_aclk);
            n++;
        end
        if (n >= 10000)
            chk("drain_timeout", 64'(sb_q.size() + hdr_q.size() + err_q.size()), 64'd0);
        repeat (2) @(posedge axi_aclk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mvalid"}, 64'(bus.m_valid), 64'd0);
        chk({tag, "_hdr"}, 64'({pack_id, pack_length, pack_type, bus.m_data, bus.m_last}), 64'd0);
        chk({tag, "_flags"}, 64'({pack_hdr_valid, pack_done, pack_err, pack_err_code}), 64'd0);
    endtask

    initial begin
        int d0;
        int e0;
        int n;
        bus.s_axis_tdata  = 8'h00;
        bus.s_axis_tvalid = 1'b0;
        repeat (3) @(posedge axi_aclk);
        #1;
        chk_outputs_zero("reset");
        axi_aresetn = 1'b1;
        repeat (2) @(posedge axi_aclk);
        #1;

        // Basic frame, continuous m_ready: bytes on consecutive cycles.
        d0 = done_cnt; e0 = err_cnt;
        hs_cyc.delete();
        send_frame(16'h1234, 13'd3, 8'h07, 8'hAA, 8'h11);
        wait_drain();
        chk("f1_done", 64'(done_cnt - d0), 64'd1);
        chk("f1_beats", 64'(hs_cyc.size()), 64'd3);
        if (hs_cyc.size() == 3) chk("f1_consec", 64'(hs_cyc[2] - hs_cyc[0]), 64'd2);

        // Garbage before the start byte is discarded.
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5B);
        send_frame(16'h1234, 13'd3, 8'h07, 8'hAA, 8'h11);
        wait_drain();
        chk("garb_done", 64'(done_cnt - d0), 64'd2);
        chk("garb_noerr", 64'(err_cnt - e0), 64'd0);

        // Zero-length frame immediately followed by a normal frame.
        send_frame(16'h0001, 13'd0, 8'h02, 8'h00, 8'h00);
        send_frame(16'h1234, 13'd3, 8'h07, 8'hAA, 8'h11);
        wait_drain();
        chk("zl_done", 64'(done_cnt - d0), 64'd4);

        // LEN upper bits set: code 2, then recovery.
        err_q.push_back(ERR_LEN_HI);
        send_byte(8'h5A); send_byte(8'h22); send_byte(8'h11);
        send_byte(8'h01); send_byte(8'h20);
        wait_drain();
        chk("lenhi_err", 64'(err_cnt - e0), 64'd1);
        send_frame(16'h1234, 13'd3, 8'h07, 8'hAA, 8'h11);
        wait_drain();

        // LEN one above MAX_LEN: code 1, header left untouched.
        err_q.push_back(ERR_LEN_MAX);
        send_byte(8'h5A); send_byte(8'h22); send_byte(8'h11);
        send_byte(8'h01); send_byte(8'h10);
        wait_drain();
        chk("lenmax_err", 64'(err_cnt - e0), 64'd2);
        chk("err_hold", 64'(pack_err_code), 64'd1);
        chk("hdr_kept", 64'({pack_id, pack_length}), 64'({16'h1234, 13'd3}));

        // LEN exactly MAX_LEN is accepted.
        send_frame(16'hBEEF, 13'd4096, 8'h44, 8'h00, 8'h01);
        wait_drain();
        chk("maxlen_noerr", 64'(err_cnt - e0), 64'd2);

        // Toggling m_ready: order preserved, tready low while blocked.
        d0 = done_cnt;
        rdy_mode = 1;
        send_frame(16'h5555, 13'd5, 8'h09, 8'h51, 8'h01);
        wait_drain();
        rdy_mode = 0;
        chk("bp_done", 64'(done_cnt - d0), 64'd1);

        // Asynchronous reset mid-payload.
        rdy_mode = 2;
        repeat (2) @(posedge axi_aclk);
        #1;
        send_byte(8'h5A); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h05); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h10);
        bus.s_axis_tvalid = 1'b0;
        chk("pre_rst_busy", 64'({bus.m_valid, pack_hdr_valid}), 64'd3);
        #2 axi_aresetn = 1'b0;
        #1;
        chk_outputs_zero("async_rst");
        rdy_mode = 0;
        repeat (2) @(posedge axi_aclk);
        #1;
        axi_aresetn = 1'b1;
        repeat (2) @(posedge axi_aclk);
        #1;
        d0 = done_cnt;
        send_frame(16'h1234, 13'd3, 8'h07, 8'hAA, 8'h11);
        wait_drain();
        chk("post_rst_done", 64'(done_cnt - d0), 64'd1);

`ifdef CCU_UNPACK_TIMEOUT_EN
        // Stall after ID_HB: timeout after TO_CYC idle cycles.
        err_q.push_back(ERR_TIMEOUT);
        send_byte(8'h5A); send_byte(8'h01); send_byte(8'h02);
        bus.s_axis_tvalid = 1'b0;
        n = 0;
        while (!pack_err && n < 300) begin
            @(negedge axi_aclk);
            n++;
        end
        chk("to_latency", 64'(n), 64'(TO_CYC));
        wait_drain();
        send_frame(16'h1234, 13'd3, 8'h07, 8'hAA, 8'h11);
        wait_drain();
`else
        n = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
